mag_latch_driver: RTL and testbench



---
 rtl/mw_pkg.sv | 17 +
 rtl/mw_tick_prescaler.sv | 27 ++
 rtl/mag_latch_driver.sv | 130 +++++++++++++
 tb/tb_mag_latch_driver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared types and default constants for the magnetron latch driver.
package mw_pkg;

    localparam int unsigned DefDiv       = 100;
    localparam int unsigned DefTimeW     = 12;
    localparam int unsigned DefAckCycles = 4;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StCook,
        StPaused,
        StDone,
        StFault
    } state_e;

endpackage

// File: rtl/mw_tick_prescaler.sv
// Divides the clock down to a one-cycle tick every DIV enabled cycles.
module mw_tick_prescaler #(
    parameter int unsigned DIV = mw_pkg::DefDiv
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == Last);

endmodule

// File: rtl/mag_latch_driver.sv
// Cooking sequencer: drives the magnetron S/R latch, counts the cook time down
// in seconds and latches a fault when the mag readback disagrees with S.
module mag_latch_driver #(
    parameter int unsigned DIV        = mw_pkg::DefDiv,
    parameter int unsigned TIME_W     = mw_pkg::DefTimeW,
    parameter int unsigned ACK_CYCLES = mw_pkg::DefAckCycles
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [TIME_W-1:0] load_val,
    input  logic              start,
    input  logic              stop,
    input  logic              door_closed,
    input  logic              mag,
    output logic              S,
    output logic              R,
    output logic [TIME_W-1:0] time_left,
    output logic              cooking,
    output logic              done,
    output logic              fault
);

    import mw_pkg::*;

    localparam int unsigned AckW = $clog2(ACK_CYCLES + 1);
    localparam logic [AckW-1:0] AckLast = AckW'(ACK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [AckW-1:0]   ack_q;
    logic              tick, presc_en, presc_clear;
    logic              mismatch, fault_hit, cook_d;

    assign presc_en    = (state_q == StCook);
    assign presc_clear = (state_q != StCook);

    mw_tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(presc_clear),
        .en   (presc_en),
        .tick (tick)
    );

    // ack_q holds the number of consecutive mismatching cycles already seen.
    assign mismatch  = (mag != S);
    assign fault_hit = mismatch && (ack_q == AckLast);
    assign cook_d    = (state_d == StCook);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (state_q != StFault && fault_hit) begin
            state_d = StFault;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load_en) begin
                        time_d  = load_val;
                        state_d = (load_val != '0) ? StArmed : StIdle;
                    end
                end
                StArmed: begin
                    if (stop) begin
                        time_d  = '0;
                        state_d = StIdle;
                    end else if (start && door_closed) begin
                        state_d = StCook;
                    end else if (load_en) begin
                        time_d  = load_val;
                        state_d = (load_val != '0) ? StArmed : StIdle;
                    end
                end
                StCook: begin
                    if (!door_closed || stop) begin
                        state_d = StPaused;
                    end else if (tick && time_q != '0) begin
                        time_d = time_q - TIME_W'(1);
                        if (time_q == TIME_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StPaused: begin
                    if (stop) begin
                        time_d  = '0;
                        state_d = StIdle;
                    end else if (start && door_closed) begin
                        state_d = StCook;
                    end
                end
                StDone:  state_d = StIdle;
                StFault: state_d = StFault;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            time_q  <= '0;
            S       <= 1'b0;
            R       <= 1'b1;
            cooking <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            S       <= cook_d;
            R       <= ~cook_d;
            cooking <= cook_d;
            done    <= (state_d == StDone);
            fault   <= (state_d == StFault);
            if (cook_d != S || !mismatch) begin
                ack_q <= '0;
            end else if (ack_q != AckLast) begin
                ack_q <= ack_q + 1'b1;
            end
        end
    end

    assign time_left = time_q;

endmodule

// File: tb/tb_mag_latch_driver.sv
// Randomized and directed bench for mag_latch_driver against a behavioural model.
module tb_mag_latch_driver;

    localparam int DIV = 4;
    localparam int ACK = 3;
    localparam int TW  = 8;

    localparam int P_IDLE = 0, P_ARM = 1, P_COOK = 2, P_PAU = 3, P_DONE = 4, P_FLT = 5;

    logic          clk = 1'b0;
    logic          rst, load_en, start, stop, door_closed;
    logic [TW-1:0] load_val;
    logic          mag = 1'b0;
    logic          S, R, cooking, done, fault;
    logic [TW-1:0] time_left;

    int checks = 0;
    int errors = 0;
    int mag_mode = 0;  // 0 follow S, 1 stuck low, 2 stuck high, 3 inverted

    mag_latch_driver #(
        .DIV       (DIV),
        .TIME_W    (TW),
        .ACK_CYCLES(ACK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .door_closed(door_closed),
        .mag        (mag),
        .S          (S),
        .R          (R),
        .time_left  (time_left),
        .cooking    (cooking),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Latch model: mag follows S one cycle later unless a fault mode is forced.
    always @(posedge clk) begin
        case (mag_mode)
            1:       mag <= 1'b0;
            2:       mag <= 1'b1;
            3:       mag <= ~S;
            default: mag <= S;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: phase, seconds left, cycles spent in the current cook run,
    // and how many consecutive cycles mag has disagreed with S.
    int m_ph = P_IDLE, m_t = 0, m_run = 0, m_miss = 0;
    bit valid = 1'b0;

    initial begin
        forever begin
            int  n_ph, n_t, n_run, n_miss;
            bit  s_old, s_new, mism;
            @(negedge clk);
            s_old = (m_ph == P_COOK);
            if (valid) begin
                chk("S", S, s_old);
                chk("R", R, !s_old);
                chk("time_left", time_left, m_t);
                chk("cooking", cooking, s_old);
                chk("done", done, m_ph == P_DONE);
                chk("fault", fault, m_ph == P_FLT);
            end
            n_ph = m_ph; n_t = m_t; n_run = 0; n_miss = 0;
            if (rst) begin
                n_ph = P_IDLE;
                n_t  = 0;
                valid = 1'b1;
            end else begin
                mism = (mag !== s_old);
                if (m_ph != P_FLT && mism && m_miss + 1 >= ACK) begin
                    n_ph = P_FLT;
                end else begin
                    if ((m_ph == P_ARM || m_ph == P_PAU) && stop) begin
                        n_ph = P_IDLE;
                        n_t  = 0;
                    end else if ((m_ph == P_ARM || m_ph == P_PAU) && start && door_closed) begin
                        n_ph = P_COOK;
                    end else if ((m_ph == P_IDLE || m_ph == P_ARM) && load_en) begin
                        n_t  = load_val;
                        n_ph = (load_val == 0) ? P_IDLE : P_ARM;
                    end else if (m_ph == P_COOK) begin
                        if (!door_closed || stop) begin
                            n_ph = P_PAU;
                        end else begin
                            n_run = m_run + 1;
                            if (m_run % DIV == DIV - 1 && m_t > 0) begin
                                n_t = m_t - 1;
                                if (n_t == 0) n_ph = P_DONE;
                            end
                        end
                    end else if (m_ph == P_DONE) begin
                        n_ph = P_IDLE;
                    end
                end
                s_new = (n_ph == P_COOK);
                if (s_new != s_old || !mism) n_miss = 0;
                else n_miss = (m_miss + 1 > ACK) ? ACK : m_miss + 1;
            end
            m_ph = n_ph; m_t = n_t; m_run = n_run; m_miss = n_miss;
        end
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        door_closed = 1'b1;
        step(3);
        rst = 1'b0;
        chk("reset_S", S, 0);
        chk("reset_R", R, 1);
        chk("reset_time", time_left, 0);
        chk("reset_flags", {cooking, done, fault}, 0);

        // Normal cook of 3 seconds
        load_en = 1'b1; load_val = 3; step(1); load_en = 1'b0;
        chk("t1_loaded", time_left, 3);
        start = 1'b1; step(1); start = 1'b0;
        chk("t1_S_rise", {S, R}, 2'b10);
        step(4); chk("t1_t2", time_left, 2);
        step(4); chk("t1_t1", time_left, 1);
        step(3); chk("t1_pre_done", {done, time_left}, {1'b0, 8'd1});
        step(1); chk("t1_done", {done, S, time_left}, {2'b10, 8'd0});
        step(1); chk("t1_after", {done, cooking, fault}, 0);

        // Door open mid-cook, then resume
        load_en = 1'b1; load_val = 5; step(1); load_en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(5); chk("t2_t4", time_left, 4);
        door_closed = 1'b0; step(1);
        chk("t2_paused", {S, cooking, time_left}, {2'b00, 8'd4});
        step(4); chk("t2_hold", time_left, 4);
        door_closed = 1'b1; start = 1'b1; step(1); start = 1'b0;
        chk("t2_resume", cooking, 1);
        step(15); chk("t2_pre_done", {done, time_left}, {1'b0, 8'd1});
        step(1); chk("t2_done", {done, time_left}, {1'b1, 8'd0});
        step(1);

        // Stop behaviour and start with door open
        load_en = 1'b1; load_val = 7; step(1); load_en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(2); stop = 1'b1; step(1);
        chk("t3_pause", {S, cooking, time_left}, {2'b00, 8'd7});
        step(1); chk("t3_clear", {cooking, time_left}, 0);
        stop = 1'b0;
        load_en = 1'b1; load_val = 6; step(1); load_en = 1'b0;
        door_closed = 1'b0; start = 1'b1; step(1);
        chk("t3_door_start", {S, time_left}, {1'b0, 8'd6});
        door_closed = 1'b1; step(1); start = 1'b0;
        chk("t3_armed_start", cooking, 1);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("t3_pause2", {cooking, time_left}, {1'b0, 8'd6});
        // start and stop together from PAUSED: stop wins
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        chk("t6_start_stop", {cooking, time_left}, 0);

        // Tick with door open leaves time_left unchanged
        load_en = 1'b1; load_val = 5; step(1); load_en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(3); door_closed = 1'b0; step(1);
        chk("t6_tick_door", {cooking, time_left}, {1'b0, 8'd5});
        door_closed = 1'b1; start = 1'b1; step(1); start = 1'b0;
        step(2); rst = 1'b1; step(1); rst = 1'b0;
        chk("t6_rst_cook", {S, R, time_left}, {2'b01, 8'd0});

        // Readback stuck low while cooking
        mag_mode = 1; step(2);
        load_en = 1'b1; load_val = 5; step(1); load_en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        chk("t4_S", S, 1);
        step(1); chk("t4_c1", {fault, S}, 2'b01);
        step(1); chk("t4_c2", {fault, S}, 2'b01);
        step(1); chk("t4_fault", {fault, S, R, time_left}, {3'b101, 8'd5});
        load_en = 1'b1; load_val = 9; start = 1'b1; stop = 1'b1; step(2);
        load_en = 1'b0; start = 1'b0; stop = 1'b0;
        chk("t4_absorb", {fault, S, cooking, time_left}, {3'b100, 8'd5});
        rst = 1'b1; mag_mode = 0; step(1); rst = 1'b0;
        chk("t4_rst", {fault, S, R, done, cooking, time_left}, {5'b00100, 8'd0});

        // load_val=0 stays IDLE; readback stuck high while idle
        load_en = 1'b1; load_val = 0; step(1); load_en = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        chk("t5_zero_load", {cooking, time_left}, 0);
        mag_mode = 2; step(1);
        chk("t5_c0", fault, 0);
        step(1); chk("t5_c1", fault, 0);
        step(1); chk("t5_c2", fault, 0);
        step(1); chk("t5_fault", fault, 1);
        rst = 1'b1; mag_mode = 0; step(1); rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            load_en     = ($urandom_range(0, 7) == 0);
            load_val    = TW'($urandom_range(0, 5));
            start       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 19) == 0);
            door_closed = ($urandom_range(0, 14) != 0);
            if (mag_mode == 3) mag_mode = 0;
            if ($urandom_range(0, 49) == 0) mag_mode = 3;
            else if ($urandom_range(0, 399) == 0) mag_mode = $urandom_range(1, 2);
            if (rst) mag_mode = 0;
            step(1);
        end
        rst = 1'b0; load_en = 1'b0; start = 1'b0; stop = 1'b0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
